li_serializer: RTL
==================

# li_serializer

Latency-insensitive width-down converter at the consumer end of a wide valid/backpressure channel. Accepts one `Width`-bit token and emits it as `Width/BeatWidth` consecutive narrow beats on a valid/backpressure output channel, least-significant beat first. It uses the same handshake as the pipeline registers, so it can sit between a wide pipeline stage and a narrow port. It sustains full output throughput by accepting the next token in the cycle the current token's last beat leaves.

## Interface
- `Name`, `""`: instance name, used only for simulation debug output.
- `Width`, `32`: input token width; must be an integer multiple of `BeatWidth`.
- `BeatWidth`, `8`: output beat width. `Beats = Width/BeatWidth`, which must be ≥1.
- Beat counter width is `max(1, $clog2(Beats))`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous, active-low reset. Asserting it clears state immediately; deassertion is synchronous to `clk` by the system.
- `d` input `Width`: input token data; sampled only when accepted.
- `d_valid` input 1: input token present.
- `d_bp` output 1: input backpressure. The token is accepted iff `d_valid && !d_bp`.
- `q` output `BeatWidth`: current beat.
- `q_valid` output 1: beat present.
- `q_bp` input 1: output backpressure. The beat leaves iff `q_valid && !q_bp`.
- `q_last` output 1: high with `q_valid` on the final beat of a token.

## Operation
- State registers:
  - `data[Width-1:0]`
  - `valid`
  - `idx` (beat index, 0..Beats-1)
- States: EMPTY (`valid=0`) and SENDING (`valid=1`).
- Combinational outputs:
  - `q = data[idx*BeatWidth +: BeatWidth]`
  - `q_valid = valid`
  - `q_last = valid && (idx == Beats-1)`
- Derived signals:
  - `outgoing = valid && !q_bp`
  - `last_out = outgoing && (idx == Beats-1)`
- `d_bp = valid && !last_out`. This is a combinational path from `q_bp` to `d_bp` and is intentional.
- `incoming = d_valid && !d_bp`.
- Transitions, evaluated in priority order:
  - `incoming` (from EMPTY, or SENDING with `last_out`): `data<=d`, `idx<=0`, `valid<=1`.
  - `last_out && !incoming`: `valid<=0`, `idx<=0`; `data` holds.
  - `outgoing && !last_out`: `idx<=idx+1`.
  - Otherwise: hold all state.
- While `valid && q_bp`, `q`, `q_last` and `idx` are stable.
- `d` is ignored whenever `d_bp=1`. `d` changing under backpressure must not affect `q`.
- `Beats==1`:
  - `idx` is constantly 0 and `q_last = valid`.
  - The block degenerates to a single-slot register that passes one token per cycle when `q_bp=0`.
- Reset (async, `resetn=0`): `valid=0`, `idx=0`, `data=0`. Outputs during and after reset: `q_valid=0`, `q_last=0`, `d_bp=0`, `q=0`.
- Reset asserted mid-token: the partially sent token is discarded. No further beats of it appear after reset.
- Under `ifdef verilator`, print `Name`, `valid`, `idx` and the current beat each cycle via the debug hook.

## Timing
- Latency: a token accepted at edge N presents beat 0 on `q` after edge N (visible in cycle N+1).
- Throughput is one beat per cycle when `q_bp=0`, with no bubble between tokens. Tokens are accepted every `Beats` cycles.
- The first token after EMPTY incurs one cycle of latency only. EMPTY never backpressures.
- A `q_bp` stall of k cycles delays all remaining beats by exactly k cycles.
- If the last beat leaves with no new token, `q_valid` is 0 the following cycle.

## Test plan
1. Width=32, BeatWidth=8, `q_bp=0`, single token `d=32'hDDCCBBAA` → `q` = `AA`,`BB`,`CC`,`DD` on 4 consecutive cycles starting 1 cycle after accept, `q_last` only with `DD`, then `q_valid=0`.
2. Back-to-back tokens `11223344` and `55667788` with `d_valid` held high → output `44,33,22,11,88,77,66,55` with no gap. `d_bp` is 1 for 3 cycles and 0 in the cycle beat `11` leaves.
3. Token `DDCCBBAA` with `q_bp=1` for 3 cycles while beat `BB` is presented → `BB` held stable 4 cycles, `idx` unchanged, `d_bp=1` throughout. Then `CC`,`DD` follow.
4. `q_bp=1` while the last beat is presented and `d_valid=1` → `d_bp=1`, new token not accepted. Release `q_bp` → new token accepted in the same cycle the last beat leaves.
5. Assert `resetn=0` asynchronously (mid-clock) after beat `BB` → `q_valid`, `q_last` and `d_bp` go to 0 immediately. After release, no stale `CC`/`DD` appear and the next token starts at beat 0.
6. Width=8, BeatWidth=8 (`Beats=1`), stream of `01,02,03` with `q_bp=0` → one beat per cycle, each with `q_last=1`. Toggling `q_bp` produces correct stalls with no loss or duplication.

Source files
------------

// File: rtl/li_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | li_serializer_if : wide input / narrow output valid-backpressure    |
// | channel pair for li_serializer.                          rev 1.0    |
// +--------------------------------------------------------------------+
interface li_serializer_if #(
  parameter int WIDTH      = 32,
  parameter int BEAT_WIDTH = 8
) ();
  logic [WIDTH-1:0]      d;
  logic                  d_valid;
  logic                  d_bp;
  logic [BEAT_WIDTH-1:0] q;
  logic                  q_valid;
  logic                  q_bp;
  logic                  q_last;

  modport master (
    output d, d_valid, q_bp,
    input  d_bp, q, q_valid, q_last
  );

  modport slave (
    input  d, d_valid, q_bp,
    output d_bp, q, q_valid, q_last
  );
endinterface
`default_nettype wire

// File: rtl/li_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | li_serializer : latency-insensitive width-down converter, emits a   |
// | WIDTH token as WIDTH/BEAT_WIDTH beats, LSB beat first.   rev 1.0    |
// +--------------------------------------------------------------------+
module li_serializer #(
  parameter string NAME       = "",
  parameter int    WIDTH      = 32,
  parameter int    BEAT_WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  li_serializer_if.slave     bus
);

  localparam int                 BEATS    = WIDTH / BEAT_WIDTH;
  localparam int                 IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic [0:0] {
    EMPTY   = 1'b0,
    SENDING = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;

  logic w_valid;
  logic w_at_last;
  logic w_outgoing;
  logic w_last_out;
  logic w_d_bp;
  logic w_incoming;

  assign w_valid    = (r_state == SENDING);
  assign w_at_last  = (r_idx == LAST_IDX);
  assign w_outgoing = w_valid && !bus.q_bp;
  assign w_last_out = w_outgoing && w_at_last;
  // Combinational q_bp -> d_bp path lets the next token enter as the last beat leaves.
  assign w_d_bp     = w_valid && !w_last_out;
  assign w_incoming = bus.d_valid && !w_d_bp;

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_idx_nxt   = r_idx;
    if (w_incoming) begin
      w_state_nxt = SENDING;
      w_data_nxt  = bus.d;
      w_idx_nxt   = '0;
    end else if (w_last_out) begin
      w_state_nxt = EMPTY;
      w_idx_nxt   = '0;
    end else if (w_outgoing) begin
      w_idx_nxt   = r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign bus.d_bp    = w_d_bp;
  assign bus.q_valid = w_valid;
  assign bus.q_last  = w_valid && w_at_last;

  generate
    if (BEATS == 1) begin : g_single
      assign bus.q = r_data[BEAT_WIDTH-1:0];
    end else begin : g_multi
      logic [BEATS-1:0][BEAT_WIDTH-1:0] w_beats;
      assign w_beats = r_data;
      assign bus.q   = w_beats[r_idx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (NAME != "") begin
      $display("%s: valid=%0b idx=%0d beat=%h", NAME, w_valid, r_idx, bus.q);
    end
  end

endmodule
`default_nettype wire
